// File: rtl/ssd_frame_decoder.sv
// Loopback receiver for the multiplexed 7-segment bus: samples scan phases,
// rebuilds the four glyphs and publishes the hex word once it is stable.
module ssd_frame_decoder #(
    parameter int SETTLE_CYC    = 4,
    parameter int STABLE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  seg_en,
    input  logic [6:0]  seg_ab,
    input  logic [6:0]  seg_cd,
    output logic [15:0] digits,
    output logic        ovf,
    output logic        frame_valid,
    output logic        update,
    output logic        code_err
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(STABLE_FRAMES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC);
    localparam logic [SW-1:0] CAP_AT     = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] STAB_MAX   = TW'(STABLE_FRAMES);
    localparam logic [TW-1:0] STAB_ONE   = TW'(1);

    typedef enum logic [1:0] {S_SYNC, S_HAVE_LO, S_HAVE_HI} state_t;

    typedef struct packed {
        logic       ok;
        logic       of;
        logic [3:0] nib;
    } glyph_t;

    function automatic glyph_t dec(input logic [6:0] s);
        glyph_t g;
        g = '{ok: 1'b1, of: 1'b0, nib: 4'h0};
        case (s)
            7'h3F:   g.nib = 4'h0;
            7'h06:   g.nib = 4'h1;
            7'h5B:   g.nib = 4'h2;
            7'h4F:   g.nib = 4'h3;
            7'h66:   g.nib = 4'h4;
            7'h6D:   g.nib = 4'h5;
            7'h7D:   g.nib = 4'h6;
            7'h07:   g.nib = 4'h7;
            7'h7F:   g.nib = 4'h8;
            7'h6F:   g.nib = 4'h9;
            7'h77:   g.nib = 4'hA;
            7'h7C:   g.nib = 4'hB;
            7'h39:   g.nib = 4'hC;
            7'h5E:   g.nib = 4'hD;
            7'h79:   g.nib = 4'hE;
            7'h71:   g.nib = 4'hF;
            7'h40:   g.of  = 1'b1;
            default: g.ok  = 1'b0;
        endcase
        return g;
    endfunction

    state_t        state;
    logic [1:0]    en_q;
    logic [SW-1:0] settle_cnt;
    logic [SW-1:0] settle_nxt;
    logic          cap;
    logic [6:0]    lo_ab, lo_cd, hi_ab, hi_cd;
    logic          frame_done;
    logic [TW-1:0] stab_cnt;
    logic [TW-1:0] stab_nxt;
    logic [16:0]   prev_w;
    logic [16:0]   pub_w;
    logic          pub_req;
    glyph_t        g3, g2, g1, g0;
    logic          all_ok, any_of, all_of, bad;
    logic [16:0]   w;

    // one capture per hold: fires only on the edge the count first hits CAP_AT
    always_comb begin
        if (seg_en != en_q)
            settle_nxt = '0;
        else if (settle_cnt == SETTLE_MAX)
            settle_nxt = settle_cnt;
        else
            settle_nxt = settle_cnt + 1'b1;
        cap = (settle_nxt == CAP_AT) && (settle_cnt != CAP_AT);
    end

    always_comb begin
        g3     = dec(lo_ab);
        g2     = dec(hi_ab);
        g1     = dec(lo_cd);
        g0     = dec(hi_cd);
        all_ok = g3.ok & g2.ok & g1.ok & g0.ok;
        any_of = g3.of | g2.of | g1.of | g0.of;
        all_of = g3.of & g2.of & g1.of & g0.of;
        bad    = !all_ok || (any_of && !all_of);
        w      = all_of ? 17'h10000
                        : {1'b0, g3.nib, g2.nib, g1.nib, g0.nib};
        if (w != prev_w)
            stab_nxt = STAB_ONE;
        else if (stab_cnt == STAB_MAX)
            stab_nxt = stab_cnt;
        else
            stab_nxt = stab_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_SYNC;
            en_q        <= 2'b00;
            settle_cnt  <= '0;
            lo_ab       <= '0;
            lo_cd       <= '0;
            hi_ab       <= '0;
            hi_cd       <= '0;
            frame_done  <= 1'b0;
            stab_cnt    <= '0;
            prev_w      <= '0;
            pub_w       <= '0;
            pub_req     <= 1'b0;
            digits      <= '0;
            ovf         <= 1'b0;
            frame_valid <= 1'b0;
            update      <= 1'b0;
            code_err    <= 1'b0;
        end else begin
            en_q       <= seg_en;
            settle_cnt <= settle_nxt;
            frame_done <= 1'b0;
            pub_req    <= 1'b0;
            update     <= 1'b0;
            code_err   <= 1'b0;

            if (cap) begin
                unique case (seg_en)
                    2'b00: begin
                        lo_ab <= seg_ab;
                        lo_cd <= seg_cd;
                        state <= S_HAVE_LO;
                    end
                    2'b11: begin
                        if (state != S_SYNC) begin
                            hi_ab      <= seg_ab;
                            hi_cd      <= seg_cd;
                            frame_done <= (state == S_HAVE_LO);
                            state      <= S_HAVE_HI;
                        end
                    end
                    default: begin
                        code_err <= 1'b1;
                        state    <= S_SYNC;
                        stab_cnt <= '0;
                    end
                endcase
            end

            if (frame_done) begin
                if (bad) begin
                    code_err <= 1'b1;
                    stab_cnt <= '0;
                end else begin
                    prev_w   <= w;
                    stab_cnt <= stab_nxt;
                    pub_w    <= w;
                    pub_req  <= (stab_nxt == STAB_MAX) &&
                                (w != {ovf, digits} || !frame_valid);
                end
            end

            if (pub_req) begin
                {ovf, digits} <= pub_w;
                frame_valid   <= 1'b1;
                update        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_frame_decoder.sv
// Directed bench for ssd_frame_decoder: one task per scenario,
// pulses counted by a negedge monitor.
module tb_ssd_frame_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  seg_en = 2'b11;
    logic [6:0]  seg_ab = '0;
    logic [6:0]  seg_cd = '0;
    logic [15:0] digits;
    logic        ovf, frame_valid, update, code_err;

    int total = 0;
    int bad   = 0;
    int upd_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    localparam logic [6:0] G1 = 7'h06, G2 = 7'h5B, G3 = 7'h4F, G4 = 7'h66;
    localparam logic [6:0] G5 = 7'h6D, G6 = 7'h7D, G7 = 7'h07, G8 = 7'h7F;
    localparam logic [6:0] GA = 7'h77, GB = 7'h7C, GC = 7'h39, GD = 7'h5E;
    localparam logic [6:0] GO = 7'h40;

    ssd_frame_decoder dut (
        .clk(clk), .rst(rst), .seg_en(seg_en), .seg_ab(seg_ab),
        .seg_cd(seg_cd), .digits(digits), .ovf(ovf),
        .frame_valid(frame_valid), .update(update), .code_err(code_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (update) upd_cnt++;
            if (code_err) err_cnt++;
            if (update && code_err) both_cnt++;
        end
    end

    task automatic phase(input logic [1:0] en, input logic [6:0] ab,
                         input logic [6:0] cd, input int n);
        seg_en = en;
        seg_ab = ab;
        seg_cd = cd;
        repeat (n) @(negedge clk);
    endtask

    // digits d3 d2 d1 d0: LO carries d3/d1, HI carries d2/d0
    task automatic frame(input logic [6:0] d3, input logic [6:0] d2,
                         input logic [6:0] d1, input logic [6:0] d0);
        phase(2'b00, d3, d1, 8);
        phase(2'b11, d2, d0, 8);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({digits, ovf, frame_valid, update, code_err} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outs got=%h %b%b%b%b want=0", digits, ovf,
                     frame_valid, update, code_err);
        end
        rst = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (err_cnt !== 0 || upd_cnt !== 0) begin
            bad++;
            $display("FAIL reset_idle got upd=%0d err=%0d want 0 0",
                     upd_cnt, err_cnt);
        end
    endtask

    task automatic test_single();
        int u0;
        u0 = upd_cnt;
        frame(G1, G2, G3, G4);
        frame(G1, G2, G3, G4);
        total++;
        if (upd_cnt !== u0 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL t1_early got upd=%0d fv=%b want %0d 0",
                     upd_cnt - u0, frame_valid, 0);
        end
        phase(2'b00, G1, G3, 8);
        phase(2'b11, G2, G4, 5);
        total++;
        if (update !== 1'b0) begin
            bad++;
            $display("FAIL t1_upd_early got=%b want=0", update);
        end
        @(negedge clk);
        total++;
        if (update !== 1'b1) begin
            bad++;
            $display("FAIL t1_upd_timing got=%b want=1", update);
        end
        repeat (2) @(negedge clk);
        total++;
        if (digits !== 16'h1234 || ovf !== 1'b0 || frame_valid !== 1'b1) begin
            bad++;
            $display("FAIL t1_word got=%h ovf=%b fv=%b want=1234 0 1",
                     digits, ovf, frame_valid);
        end
        frame(G1, G2, G3, G4);
        total++;
        if (upd_cnt !== u0 + 1) begin
            bad++;
            $display("FAIL t1_no_repeat got=%0d want=%0d", upd_cnt - u0, 1);
        end
    endtask

    task automatic test_change();
        int u0;
        u0 = upd_cnt;
        frame(GA, GB, GC, GD);
        frame(GA, GB, GC, GD);
        total++;
        if (digits !== 16'h1234 || upd_cnt !== u0) begin
            bad++;
            $display("FAIL t2_hold got=%h upd=%0d want=1234 0",
                     digits, upd_cnt - u0);
        end
        frame(GA, GB, GC, GD);
        total++;
        if (digits !== 16'hABCD || upd_cnt !== u0 + 1) begin
            bad++;
            $display("FAIL t2_new got=%h upd=%0d want=abcd 1",
                     digits, upd_cnt - u0);
        end
    endtask

    task automatic test_overflow();
        int u0, e0;
        u0 = upd_cnt;
        e0 = err_cnt;
        repeat (3) frame(GO, GO, GO, GO);
        total++;
        if (ovf !== 1'b1 || digits !== 16'h0000 || upd_cnt !== u0 + 1) begin
            bad++;
            $display("FAIL t3_ovf got ovf=%b d=%h upd=%0d want 1 0000 1",
                     ovf, digits, upd_cnt - u0);
        end
        frame(GO, GO, GO, G1);
        total++;
        if (err_cnt !== e0 + 1 || ovf !== 1'b1 || digits !== 16'h0000) begin
            bad++;
            $display("FAIL t3_mixed got err=%0d ovf=%b d=%h want 1 1 0000",
                     err_cnt - e0, ovf, digits);
        end
        frame(G1, 7'h00, G3, G4);
        total++;
        if (err_cnt !== e0 + 2 || upd_cnt !== u0 + 1) begin
            bad++;
            $display("FAIL t3_undec got err=%0d upd=%0d want 2 1",
                     err_cnt - e0, upd_cnt - u0);
        end
    endtask

    task automatic test_illegal();
        int u0, e0;
        u0 = upd_cnt;
        e0 = err_cnt;
        frame(GA, GB, GC, GD);
        frame(GA, GB, GC, GD);
        phase(2'b00, GA, GC, 8);
        phase(2'b01, GA, GC, 6);
        total++;
        if (err_cnt !== e0 + 1) begin
            bad++;
            $display("FAIL t4_err got=%0d want=1", err_cnt - e0);
        end
        phase(2'b11, GB, GD, 8);
        frame(GA, GB, GC, GD);
        total++;
        if (upd_cnt !== u0 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL t4_restart got upd=%0d ovf=%b want 0 1",
                     upd_cnt - u0, ovf);
        end
        frame(GA, GB, GC, GD);
        frame(GA, GB, GC, GD);
        total++;
        if (upd_cnt !== u0 + 1 || digits !== 16'hABCD || ovf !== 1'b0) begin
            bad++;
            $display("FAIL t4_pub got upd=%0d d=%h ovf=%b want 1 abcd 0",
                     upd_cnt - u0, digits, ovf);
        end
    endtask

    task automatic test_glitch();
        int u0, e0;
        u0 = upd_cnt;
        e0 = err_cnt;
        repeat (3) begin
            phase(2'b00, G5, G7, 8);
            phase(2'b10, G5, G7, 2);
            phase(2'b11, G6, G8, 8);
        end
        total++;
        if (err_cnt !== e0) begin
            bad++;
            $display("FAIL t5_err got=%0d want=0", err_cnt - e0);
        end
        total++;
        if (upd_cnt !== u0 + 1 || digits !== 16'h5678) begin
            bad++;
            $display("FAIL t5_pub got upd=%0d d=%h want 1 5678",
                     upd_cnt - u0, digits);
        end
    endtask

    task automatic test_reset_mid();
        int u0;
        phase(2'b00, G1, G3, 8);
        phase(2'b11, G2, G4, 1);
        rst = 1'b0;
        #1;
        total++;
        if ({digits, ovf, frame_valid, update, code_err} !== 20'h0) begin
            bad++;
            $display("FAIL t6_async got=%h %b%b%b%b want=0", digits, ovf,
                     frame_valid, update, code_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        u0 = upd_cnt;
        repeat (8) @(negedge clk);
        frame(G1, G2, G3, G4);
        frame(G1, G2, G3, G4);
        total++;
        if (upd_cnt !== u0 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL t6_partial got upd=%0d fv=%b want 0 0",
                     upd_cnt - u0, frame_valid);
        end
        frame(G1, G2, G3, G4);
        total++;
        if (upd_cnt !== u0 + 1 || digits !== 16'h1234) begin
            bad++;
            $display("FAIL t6_pub got upd=%0d d=%h want 1 1234",
                     upd_cnt - u0, digits);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_change();
        test_overflow();
        test_illegal();
        test_glitch();
        test_reset_mid();
        total++;
        if (both_cnt !== 0) begin
            bad++;
            $display("FAIL upd_err_overlap got=%0d want=0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
